rv_mem_port: RTL
================

# rv_mem_port

Parametrised data-memory port for the multicycle RV core. It sits between the shared 32/64-bit databus and the RAM. It latches the address and write data from the bus, then runs a req/ready handshake with variable-latency memory. It supports byte, half, word and dword accesses, with lane alignment, byte enables and load sign/zero extension. Successor to the fixed single-cycle word-only RAM hookup: adds sub-word access, wait states, misalignment detection and an optional timeout.

## Interface
Parameters:
- XLEN, 32, data width; 32 or 64 only
- ADDR_W, 10, RAM word-address width
- TIMEOUT, 16, maximum wait cycles for mem_ready (used only with the macro)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- databus  in  XLEN  shared datapath bus
- addr_en  in  1  latch databus into address register (ignored while busy)
- wd_en  in  1  latch databus into write-data register (ignored while busy)
- req  in  1  start access; sampled only in IDLE
- we  in  1  1 = store, 0 = load; sampled with req
- size  in  2  00 byte, 01 half, 10 word, 11 dword; sampled with req
- uns  in  1  zero-extend load; sampled with req
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- rd_data  out  XLEN  extended load result; held until next load completes
- err_misalign  out  1  valid with done
- err_timeout  out  1  valid with done
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  word address
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_rdata  in  XLEN  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion; only meaningful while mem_req=1

## Operation
- OFF = log2(XLEN/8). mem_addr = addr_q[ADDR_W+OFF-1:OFF]. Upper address bits are ignored, so addresses wrap modulo RAM size.
- States: IDLE, REQ, RESP.
- IDLE, req=1:
  - Illegal size (11 when XLEN=32) or misaligned (addr_q[size-1:0] != 0) goes to RESP with err_misalign=1. No memory request is made.
  - Otherwise latch we/size/uns and go to REQ.
- REQ:
  - mem_req=1. mem_we/mem_be/mem_addr/mem_wdata stay stable until mem_ready.
  - mem_be = ((1<<(1<<size))-1) << addr_q[OFF-1:0].
  - mem_wdata = wd_q << 8*addr_q[OFF-1:0].
  - On mem_ready: a load captures (mem_rdata >> 8*offset), truncated to size and sign-extended (uns=0) or zero-extended (uns=1), into rd_data. Then go to RESP.
- RESP: done=1 for one cycle, then IDLE. The error flags are cleared when the next access starts.
- Stores and errored accesses leave rd_data unchanged.
- req while busy is ignored and is not queued.
- mem_ready outside REQ is ignored.

## Timing
- Reset: state IDLE. addr_q, wd_q, rd_data, busy, done, both error flags and all mem_* outputs are 0.
- Reset mid-access aborts immediately; mem_req is 0 from the cycle after the reset edge.
- req sampled at edge 0, then mem_req high from cycle 1.
- Zero-wait memory (mem_ready in cycle 1) gives done in cycle 2. Latency = 2 + wait cycles.
- Misaligned access: done with err_misalign in cycle 1.
- addr_en and req in the same cycle: the access uses the previously latched address. Latch the address at least one cycle before req.
- rd_data is valid in the done cycle and after it.

## Configuration
- RV_MEM_TIMEOUT_EN defined:
  - A wait counter is cleared on entry to REQ and increments each REQ cycle without mem_ready.
  - If the count reaches TIMEOUT without mem_ready, the access aborts to RESP with err_timeout=1, and rd_data is unchanged.
  - mem_ready in the same cycle as expiry wins: normal completion.
- Undefined: REQ waits indefinitely, err_timeout is tied to 0, and no counter is built.

## Structure
- Package rv_mem_pkg:
  - state enum (IDLE, REQ, RESP)
  - size enum (MEM_B, MEM_H, MEM_W, MEM_D)
  - byte-mask function
- Sub-module rv_mem_align (combinational):
  - store lane shift and byte-enable generation
  - load shift and extension
  - instantiated once

## Test plan
- Word store then load, XLEN=32:
  - Store: databus addr 0x10, data 0xDEADBEEF, size 10, zero wait gives mem_addr=4, mem_be=1111, done at cycle 2.
  - Load: size 10 returns rd_data=0xDEADBEEF.
- Byte load, signed and unsigned:
  - Address 0x13, mem_rdata 0x80FF_0000, uns=0, size 00 gives rd_data=0xFFFFFF80.
  - Same access with uns=1 gives 0x00000080.
- Half store to 0x22, data 0x1234, gives mem_be=1100 and mem_wdata=0x12340000.
- Misaligned half at 0x21 gives done at cycle 1 with err_misalign=1 and mem_req never asserted.
- Wait states: mem_ready delayed 5 cycles gives done at cycle 7 with mem_* stable throughout. A req pulsed mid-wait is ignored.
- With RV_MEM_TIMEOUT_EN and TIMEOUT=4, no ready gives err_timeout with done at cycle 6. rst asserted in the middle of an access drops busy/mem_req the next cycle.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared types and helpers for the RV data-memory port.
// Covers access-size encoding, FSM states and per-size byte/alignment masks.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10,
        MEM_D = 2'b11
    } size_t;

    // Byte enables for an access of this size starting at lane 0.
    function automatic logic [7:0] byte_mask(input size_t sz);
        case (sz)
            MEM_B:   byte_mask = 8'h01;
            MEM_H:   byte_mask = 8'h03;
            MEM_W:   byte_mask = 8'h0F;
            default: byte_mask = 8'hFF;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input size_t sz);
        case (sz)
            MEM_B:   align_mask = 3'b000;
            MEM_H:   align_mask = 3'b001;
            MEM_W:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/rv_mem_align.sv
// Combinational lane steering: store shift + byte enables, load shift + sign/zero extension.
// Zero latency; no flow control of its own.
module rv_mem_align
    import rv_mem_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int OFF  = $clog2(XLEN / 8),
    localparam int BE_W = XLEN / 8
) (
    input  logic [XLEN-1:0] wd,
    input  logic [XLEN-1:0] rdata,
    input  logic [OFF-1:0]  offset,
    input  logic [1:0]      size,
    input  logic            uns,
    output logic [BE_W-1:0] be,
    output logic [XLEN-1:0] wdata_sh,
    output logic [XLEN-1:0] rdata_ext
);

    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] low_mask;
    logic            fill;

    assign be       = BE_W'(byte_mask(size_t'(size))) << offset;
    assign wdata_sh = wd << {offset, 3'b000};
    assign sh       = rdata >> {offset, 3'b000};

    // Keep the low bytes of the access, then fill the rest with the sign or zeros.
    always_comb begin
        low_mask = '1;
        fill     = 1'b0;
        case (size_t'(size))
            MEM_B: begin
                low_mask = XLEN'(64'h0000_0000_0000_00FF);
                fill     = sh[7] & ~uns;
            end
            MEM_H: begin
                low_mask = XLEN'(64'h0000_0000_0000_FFFF);
                fill     = sh[15] & ~uns;
            end
            MEM_W: begin
                low_mask = XLEN'(64'h0000_0000_FFFF_FFFF);
                fill     = sh[31] & ~uns;
            end
            default: begin
                low_mask = '1;
                fill     = 1'b0;
            end
        endcase
        rdata_ext = (sh & low_mask) | ({XLEN{fill}} & ~low_mask);
    end

endmodule

// File: rtl/rv_mem_port.sv
// Data-memory port: latches address/store data from the databus, runs a req/ready access to RAM.
// Latency 2 + wait cycles (1 for a rejected misaligned access); new req ignored while busy.
// Optional RV_MEM_TIMEOUT_EN aborts an access after TIMEOUT cycles without mem_ready.
module rv_mem_port
    import rv_mem_pkg::*;
#(
    parameter  int XLEN    = 32,
    parameter  int ADDR_W  = 10,
    parameter  int TIMEOUT = 16,
    localparam int OFF     = $clog2(XLEN / 8),
    localparam int BE_W    = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   databus,
    input  logic              addr_en,
    input  logic              wd_en,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   rd_data,
    output logic              err_misalign,
    output logic              err_timeout,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready
);

    localparam int AQ_W = ADDR_W + OFF;

    if ((XLEN != 32 && XLEN != 64) || TIMEOUT < 1) begin : g_bad_param
        $error("rv_mem_port: XLEN must be 32 or 64 and TIMEOUT at least 1");
    end

    state_t          state, state_nx;
    logic [AQ_W-1:0] addr_q;
    logic [XLEN-1:0] wd_q;
    logic            we_q;
    size_t           size_q;
    logic            uns_q;
    logic            start, bad, expire;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata_sh, ld_data;

    assign start = (state == IDLE) && req;
    assign bad   = ((XLEN == 32) && (size == 2'b11)) ||
                   ((addr_q[2:0] & align_mask(size_t'(size))) != 3'b000);
    assign busy  = (state != IDLE);
    assign done  = (state == RESP);

    rv_mem_align #(.XLEN(XLEN)) u_align (
        .wd        (wd_q),
        .rdata     (mem_rdata),
        .offset    (addr_q[OFF-1:0]),
        .size      (size_q),
        .uns       (uns_q),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .rdata_ext (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            wd_q         <= '0;
            we_q         <= 1'b0;
            size_q       <= MEM_B;
            uns_q        <= 1'b0;
            rd_data      <= '0;
            err_misalign <= 1'b0;
        end else begin
            state <= state_nx;
            // Latching is suppressed on the req cycle so an access never sees a half-updated address.
            if (state == IDLE && !req) begin
                if (addr_en) addr_q <= databus[AQ_W-1:0];
                if (wd_en)   wd_q   <= databus;
            end
            if (start) begin
                we_q         <= we;
                size_q       <= size_t'(size);
                uns_q        <= uns;
                err_misalign <= bad;
            end
            if (state == REQ && mem_ready && !we_q) rd_data <= ld_data;
        end
    end

`ifdef RV_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != REQ) wait_cnt <= '0;
        else if (!mem_ready)     wait_cnt <= wait_cnt + CNT_W'(1);
    end

    // A ready arriving on the expiry cycle still completes normally.
    assign expire = (state == REQ) && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst || start) err_timeout <= 1'b0;
        else if (expire)  err_timeout <= 1'b1;
    end
`else
    assign expire      = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        case (state)
            IDLE: if (req) state_nx = bad ? RESP : REQ;
            REQ: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q[AQ_W-1:OFF];
                mem_be    = be;
                mem_wdata = wdata_sh;
                if (mem_ready || expire) state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule
